// File: rtl/noc_sync_pkg.sv
// Shared constants for the NoC asynchronous channel boundary (sender and receiver sides).
//   HS_FOUR_PHASE / HS_TWO_PHASE : handshake protocol selectors
//   DEFAULT_DATA_WIDTH           : default flit width
//   DEFAULT_SYNC_STAGES          : default synchroniser depth
package noc_sync_pkg;

  localparam int unsigned HS_FOUR_PHASE       = 0;
  localparam int unsigned HS_TWO_PHASE        = 1;
  localparam int unsigned DEFAULT_DATA_WIDTH  = 34;
  localparam int unsigned DEFAULT_SYNC_STAGES = 3;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for signals arriving from a foreign clock domain.
//   clock : local clock
//   reset : synchronous, active-low; clears every stage
//   d     : asynchronous input
//   q     : output of the last stage (STAGES cycles of latency)
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_receiver_fifo.sv
// Receiver side of the NoC asynchronous channel boundary. Accepts req/ack handshaked words
// from a foreign clock domain, synchronises req, and buffers words in a BUFFER_SIZE-deep FIFO
// that feeds the local router port.
//   clock, reset : local clock; synchronous active-low reset
//   req, data_in : remote request and bundled data (data stable until ack answers)
//   ack          : registered acknowledge back to the sender
//   data_out     : FIFO head word
//   valid_out    : active-low, 0 = data_out valid
//   stop_out     : downstream stall, 1 = do not pop
//   chnl_stop    : registered full flag
//   count        : FIFO occupancy
module sync_receiver_fifo
  import noc_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned TWO_PHASE   = HS_FOUR_PHASE
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               req,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               ack,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               valid_out,
  input  logic                               stop_out,
  output logic                               chnl_stop,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   count
);

  localparam int unsigned PtrWidth = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned CntWidth = $clog2(BUFFER_SIZE + 1);
  localparam bit          TwoPhase = (TWO_PHASE == HS_TWO_PHASE);

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  localparam ptr_t LastIdx   = ptr_t'(BUFFER_SIZE - 1);
  localparam cnt_t FullCount = cnt_t'(BUFFER_SIZE);

  logic                  req_sync;
  logic                  ack_q, ack_d;
  logic                  full_q, full_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  count_q, count_d;
  logic [DATA_WIDTH-1:0] storage_q [BUFFER_SIZE];

  logic pending, data_phase, rtz_phase, push, pop;

  // Raw req is sampled only here.
  sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clock (clock),
    .reset (reset),
    .d     (req),
    .q     (req_sync)
  );

  always_comb begin
    pending    = (req_sync != ack_q);
    // Two-phase: every transition carries data. Four-phase: only the rising half does.
    data_phase = TwoPhase ? pending : (req_sync & ~ack_q);
    rtz_phase  = TwoPhase ? 1'b0 : (~req_sync & ack_q);

    // Push is gated by the registered full flag, so a pop while full frees space only for
    // the following cycle (no bypass).
    push = data_phase & ~full_q;
    pop  = (count_q != '0) & ~stop_out;

    ack_d = ack_q;
    if (push) begin
      ack_d = req_sync;
    end else if (rtz_phase) begin
      ack_d = 1'b0;
    end

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + ptr_t'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + ptr_t'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop && !push) begin
      count_d = count_q - cnt_t'(1);
    end

    full_d = (count_d == FullCount);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      full_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      ack_q    <= ack_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        storage_q[wr_ptr_q] <= data_in;
      end
    end
  end

  assign ack       = ack_q;
  assign chnl_stop = full_q;
  assign count     = count_q;
  assign valid_out = (count_q == '0);
  assign data_out  = storage_q[rd_ptr_q];

endmodule

// File: doc/sync_receiver_fifo.md
Name: sync_receiver_fifo

Overview:
- Parametrised successor receiver for the NoC asynchronous channel boundary.
- Takes a req/ack handshake plus bundled data from a foreign clock domain and synchronises req through a configurable flop chain.
- Stores words in a real BUFFER_SIZE-deep FIFO and presents them to the local router port with active-low valid and stop backpressure.
- Supports four-phase and two-phase signalling. Backpressure is applied by withholding ack when the FIFO is full; data is never dropped.

Parameters:
- DATA_WIDTH, 34: flit width.
- BUFFER_SIZE, 4: FIFO depth in words; legal range >=1, need not be a power of 2.
- SYNC_STAGES, 3: synchroniser flops on req; legal range >=2.
- TWO_PHASE, 0: 0 = four-phase return-to-zero, 1 = two-phase transition signalling.

Ports:
- clock, input, 1: local clock; all state on posedge.
- reset, input, 1: synchronous, active-low reset.
- req, input, 1: request from remote sender; asynchronous to clock.
- data_in, input, DATA_WIDTH: bundled data; sender holds it stable from req change until the matching ack change.
- ack, output, 1: acknowledge to sender; registered.
- data_out, output, DATA_WIDTH: FIFO head word.
- valid_out, output, 1: active-low; 0 = data_out holds a valid word.
- stop_out, input, 1: downstream stall; 1 = do not pop.
- chnl_stop, output, 1: 1 = FIFO full (count == BUFFER_SIZE); registered.
- count, output, $clog2(BUFFER_SIZE+1): current occupancy.

Behaviour:
- Reset (reset==0 at posedge):
  - ack=0, valid_out=1, chnl_stop=0, count=0, data_out=0.
  - Synchroniser flops, read pointer, write pointer and storage are all cleared to 0.
  - Reset mid-transfer abandons the handshake. The sender must be reset in the same window.
- Synchroniser: req_sync is the output of SYNC_STAGES flops in series. No other logic samples raw req.
- A transfer is pending when req_sync != ack.
- Four-phase mode (TWO_PHASE=0):
  - req_sync=1, ack=0: data phase. If count<BUFFER_SIZE, write data_in to the FIFO and set ack<=1 in the same edge. If full, hold ack=0 until space exists.
  - req_sync=0, ack=1: return-to-zero phase. Set ack<=0 unconditionally; no FIFO write.
- Two-phase mode (TWO_PHASE=1): any req_sync != ack is a data phase. If count<BUFFER_SIZE, write data_in and set ack<=req_sync.
- Latency:
  - A req change that settles before edge E reaches req_sync after edge E+SYNC_STAGES-1.
  - Write and ack update occur at edge E+SYNC_STAGES.
  - valid_out goes low after that same edge (count>0), i.e. SYNC_STAGES+1 edges from the req change when the FIFO is not full.
- Pop: when valid_out==0 and stop_out==0, the read pointer advances at the posedge.
- data_out = storage[rd_ptr] (combinational read of registered storage). It is undefined in value but stable while valid_out==1.
- FIFO bookkeeping:
  - Pointers wrap from BUFFER_SIZE-1 to 0 explicitly.
  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Full: push is gated by the registered full flag. Push+pop in the same cycle while full does not push; the push happens on the next cycle. No bypass path.
- Empty: valid_out=1; stop_out is ignored; the pointers do not move.
- stop_out held high indefinitely: the FIFO fills, chnl_stop=1, and ack stalls. The sender is stalled losslessly.
- Throughput:
  - Four-phase: at most 1 word per 2*(SYNC_STAGES+1) cycles plus sender-side latency.
  - Two-phase: at most 1 word per SYNC_STAGES+1 cycles.
- valid_out and chnl_stop are derived from registered count only; no combinational path from req.

Decomposition:
- Shared package noc_sync_pkg:
  - HS_FOUR_PHASE=0 and HS_TWO_PHASE=1 constants.
  - Default DATA_WIDTH and SYNC_STAGES constants.
- Sub-module sync_chain: parametrised N-flop synchroniser (WIDTH, STAGES) with synchronous active-low reset. It is reused by the matching sender for the ack path.
- FIFO storage and pointers stay inline.

Test Plan:
- Four-phase single word (SYNC_STAGES=3): data_in=34'h2_DEAD_BEEF, req rises before edge 10 -> ack=1 and valid_out=0 after edge 13; data_out=34'h2_DEAD_BEEF. req falls before edge 20 -> ack=0 after edge 23. Pop with stop_out=0 -> valid_out=1.
- Fill and backpressure (BUFFER_SIZE=4, stop_out=1): send 5 words 1..5 -> count=4 and chnl_stop=1 after word 4; word 5 is not acked. Drop stop_out for one cycle -> word 1 is popped, then word 5 is acked. Output order is 2,3,4,5.
- Two-phase mode (TWO_PHASE=1): toggle req 4 times carrying 8'hA0..8'hA3 -> ack toggles to match req each time. FIFO emits A0..A3 in order; no RTZ cycles.
- Simultaneous push/pop at count=2: count stays 2; pointers wrap correctly across index 3->0 over 10 words.
- Reset mid-transfer: assert reset after req rises but before ack -> ack=0, valid_out=1, count=0, chnl_stop=0. The first post-reset word is received cleanly.
- Non-power-of-2 depth (BUFFER_SIZE=3) and SYNC_STAGES=2: stream 9 words with random stop_out -> no loss or duplication; count never exceeds 3; latency is 3 edges.
